// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard/stall controller for a classic 5-stage in-order pipeline.
// Decides each cycle whether the front end advances, inserts a load-use
// bubble, flushes a wrongly fetched instruction after a taken branch, or
// freezes the whole pipeline while data memory is busy. Also keeps three
// saturating event counters for performance monitoring.
//
// Parameters
//   CNT_W            width of each event counter
//
// Ports
//   clk_i            clock, all state updates on the rising edge
//   rst_i            asynchronous active-low reset
//   start_i          releases the pipeline from IDLE (ignored elsewhere)
//   IFID_rs1_i       rs1 of the instruction in ID
//   IFID_rs2_i       rs2 of the instruction in ID
//   IDEX_MemRead_i   instruction in EX is a load
//   IDEX_rd_i        destination register of the instruction in EX
//   Branch_taken_i   branch resolved taken in ID
//   mem_stall_i      data memory busy
//   NoOp_o           decoder emits all-zero controls (bubble)
//   PCWrite_o        PC update enable
//   IFID_Write_o     IF/ID register update enable
//   IFID_Flush_o     clear IF/ID to a nop
//   Freeze_o         hold every pipeline register
//   stall_cnt_o      number of load-use bubbles inserted
//   flush_cnt_o      number of branch flushes
//   freeze_cnt_o     number of cycles with Freeze_o asserted
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [4:0]       IFID_rs1_i,
    input  logic [4:0]       IFID_rs2_i,
    input  logic             IDEX_MemRead_i,
    input  logic [4:0]       IDEX_rd_i,
    input  logic             Branch_taken_i,
    input  logic             mem_stall_i,
    output logic             NoOp_o,
    output logic             PCWrite_o,
    output logic             IFID_Write_o,
    output logic             IFID_Flush_o,
    output logic             Freeze_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] freeze_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FREEZE = 2'd2
    } state_t;

    // Counter slots inside the counter array
    localparam int CNT_STALL  = 0;
    localparam int CNT_FLUSH  = 1;
    localparam int CNT_FREEZE = 2;
    localparam int NUM_CNT    = 3;

    state_t state_q, state_d;

    logic             hz;
    logic [NUM_CNT-1:0] cnt_inc;
    logic [CNT_W-1:0] cnt_q [NUM_CNT];
    logic [CNT_W-1:0] cnt_d [NUM_CNT];

    // Load-use hazard: the load in EX writes a register the ID instruction
    // reads. x0 is never a real dependency.
    assign hz = IDEX_MemRead_i
              & (IDEX_rd_i != 5'd0)
              & ((IDEX_rd_i == IFID_rs1_i) | (IDEX_rd_i == IFID_rs2_i));

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and Mealy outputs.
    // RUN and FREEZE share the same decision logic: FREEZE drops back to RUN
    // the very cycle mem_stall_i falls, and RUN rules already apply in that
    // cycle, so the only difference between them is the state label.
    // Priority: memory stall, then load-use bubble, then branch flush.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        NoOp_o       = 1'b1;
        PCWrite_o    = 1'b0;
        IFID_Write_o = 1'b0;
        IFID_Flush_o = 1'b0;
        Freeze_o     = 1'b0;
        cnt_inc      = '0;

        case (state_q)
            ST_RUN, ST_FREEZE: begin
                state_d = ST_RUN;
                if (mem_stall_i) begin
                    NoOp_o   = 1'b0;
                    Freeze_o = 1'b1;
                    state_d  = ST_FREEZE;
                    cnt_inc[CNT_FREEZE] = 1'b1;
                end else if (hz) begin
                    // Bubble; a coincident taken branch is re-evaluated
                    // once the dependent instruction proceeds.
                    NoOp_o = 1'b1;
                    cnt_inc[CNT_STALL] = 1'b1;
                end else if (Branch_taken_i) begin
                    NoOp_o       = 1'b0;
                    PCWrite_o    = 1'b1;
                    IFID_Write_o = 1'b1;
                    IFID_Flush_o = 1'b1;
                    cnt_inc[CNT_FLUSH] = 1'b1;
                end else begin
                    NoOp_o       = 1'b0;
                    PCWrite_o    = 1'b1;
                    IFID_Write_o = 1'b1;
                end
            end
            default: begin
                // IDLE (and any illegal encoding): hold the front end.
                state_d = start_i ? ST_RUN : ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Saturating event counters
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
            always_comb begin
                cnt_d[gi] = cnt_q[gi];
                if (cnt_inc[gi] && !(&cnt_q[gi])) begin
                    cnt_d[gi] = cnt_q[gi] + 1'b1;
                end
            end

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    cnt_q[gi] <= '0;
                end else begin
                    cnt_q[gi] <= cnt_d[gi];
                end
            end
        end
    endgenerate

    assign stall_cnt_o  = cnt_q[CNT_STALL];
    assign flush_cnt_o  = cnt_q[CNT_FLUSH];
    assign freeze_cnt_o = cnt_q[CNT_FREEZE];

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic [4:0] IFID_rs1_i;
    logic [4:0] IFID_rs2_i;
    logic       IDEX_MemRead_i;
    logic [4:0] IDEX_rd_i;
    logic       Branch_taken_i;
    logic       mem_stall_i;

    // Wide-counter instance
    logic        NoOp_o, PCWrite_o, IFID_Write_o, IFID_Flush_o, Freeze_o;
    logic [31:0] stall_cnt_o, flush_cnt_o, freeze_cnt_o;
    // Narrow-counter instance (saturation)
    logic        s_NoOp_o, s_PCWrite_o, s_IFID_Write_o, s_IFID_Flush_o, s_Freeze_o;
    logic [1:0]  s_stall_cnt_o, s_flush_cnt_o, s_freeze_cnt_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    pipeline_hazard_ctrl #(.CNT_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .IFID_rs1_i(IFID_rs1_i), .IFID_rs2_i(IFID_rs2_i),
        .IDEX_MemRead_i(IDEX_MemRead_i), .IDEX_rd_i(IDEX_rd_i),
        .Branch_taken_i(Branch_taken_i), .mem_stall_i(mem_stall_i),
        .NoOp_o(NoOp_o), .PCWrite_o(PCWrite_o), .IFID_Write_o(IFID_Write_o),
        .IFID_Flush_o(IFID_Flush_o), .Freeze_o(Freeze_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o),
        .freeze_cnt_o(freeze_cnt_o)
    );

    pipeline_hazard_ctrl #(.CNT_W(2)) dut_sat (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .IFID_rs1_i(IFID_rs1_i), .IFID_rs2_i(IFID_rs2_i),
        .IDEX_MemRead_i(IDEX_MemRead_i), .IDEX_rd_i(IDEX_rd_i),
        .Branch_taken_i(Branch_taken_i), .mem_stall_i(mem_stall_i),
        .NoOp_o(s_NoOp_o), .PCWrite_o(s_PCWrite_o), .IFID_Write_o(s_IFID_Write_o),
        .IFID_Flush_o(s_IFID_Flush_o), .Freeze_o(s_Freeze_o),
        .stall_cnt_o(s_stall_cnt_o), .flush_cnt_o(s_flush_cnt_o),
        .freeze_cnt_o(s_freeze_cnt_o)
    );

    typedef struct {
        logic       start;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       mr;
        logic [4:0] rd;
        logic       br;
        logic       ms;
        logic [4:0] outs;   // {NoOp, PCWrite, IFID_Write, IFID_Flush, Freeze}
        int         stall;  // counter values after the edge (wide instance)
        int         flush;
        int         freeze;
    } vec_t;

    localparam int NV = 18;
    vec_t tbl [NV];

    localparam logic [4:0] O_IDLE   = 5'b10000;
    localparam logic [4:0] O_NORM   = 5'b01100;
    localparam logic [4:0] O_BUBBLE = 5'b10000;
    localparam logic [4:0] O_FLUSH  = 5'b01110;
    localparam logic [4:0] O_FREEZE = 5'b00001;

    function automatic vec_t mk(input logic st, input int rs1, input int rs2,
                                input logic mr, input int rd, input logic br,
                                input logic ms, input logic [4:0] o,
                                input int sc, input int fc, input int zc);
        vec_t v;
        v.start = st; v.rs1 = rs1[4:0]; v.rs2 = rs2[4:0]; v.mr = mr;
        v.rd = rd[4:0]; v.br = br; v.ms = ms; v.outs = o;
        v.stall = sc; v.flush = fc; v.freeze = zc;
        return v;
    endfunction

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic chk(input string name, input int idx, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic chk_outs(input string name, input int idx, input logic [4:0] exp);
        chk({name, ".outs"},   idx, {NoOp_o, PCWrite_o, IFID_Write_o, IFID_Flush_o, Freeze_o}, exp);
        chk({name, ".s_outs"}, idx, {s_NoOp_o, s_PCWrite_o, s_IFID_Write_o, s_IFID_Flush_o, s_Freeze_o}, exp);
    endtask

    task automatic chk_cnts(input string name, input int idx, input int sc, input int fc, input int zc);
        chk({name, ".stall"},    idx, stall_cnt_o,    sc);
        chk({name, ".flush"},    idx, flush_cnt_o,    fc);
        chk({name, ".freeze"},   idx, freeze_cnt_o,   zc);
        chk({name, ".s_stall"},  idx, s_stall_cnt_o,  sat3(sc));
        chk({name, ".s_flush"},  idx, s_flush_cnt_o,  sat3(fc));
        chk({name, ".s_freeze"}, idx, s_freeze_cnt_o, sat3(zc));
    endtask

    task automatic drive(input vec_t v);
        start_i = v.start; IFID_rs1_i = v.rs1; IFID_rs2_i = v.rs2;
        IDEX_MemRead_i = v.mr; IDEX_rd_i = v.rd;
        Branch_taken_i = v.br; mem_stall_i = v.ms;
    endtask

    initial begin
        //            st rs1 rs2 mr rd br ms  outputs   stall flush freeze
        tbl[0]  = mk(0,  0,  0, 0,  0, 0, 0, O_IDLE,   0, 0, 0);
        tbl[1]  = mk(1,  0,  0, 0,  0, 0, 0, O_IDLE,   0, 0, 0); // start -> RUN
        tbl[2]  = mk(0,  1,  2, 0,  0, 0, 0, O_NORM,   0, 0, 0);
        tbl[3]  = mk(0,  0,  3, 1,  0, 0, 0, O_NORM,   0, 0, 0); // rd=x0: no stall
        tbl[4]  = mk(1,  1,  2, 0,  0, 0, 0, O_NORM,   0, 0, 0); // start ignored
        tbl[5]  = mk(0,  1,  5, 1,  5, 0, 0, O_BUBBLE, 1, 0, 0); // rs2 match
        tbl[6]  = mk(0,  7,  2, 1,  7, 1, 0, O_BUBBLE, 2, 0, 0); // branch + hz
        tbl[7]  = mk(0,  3,  4, 1,  7, 1, 0, O_FLUSH,  2, 1, 0); // branch after bubble
        tbl[8]  = mk(0,  5,  1, 1,  5, 0, 1, O_FREEZE, 2, 1, 1);
        tbl[9]  = mk(0,  5,  1, 1,  5, 0, 1, O_FREEZE, 2, 1, 2);
        tbl[10] = mk(0,  5,  1, 1,  5, 0, 1, O_FREEZE, 2, 1, 3);
        tbl[11] = mk(0,  5,  1, 1,  5, 0, 0, O_BUBBLE, 3, 1, 3); // exit freeze, bubble
        tbl[12] = mk(0,  5,  1, 0,  5, 1, 0, O_FLUSH,  3, 2, 3);
        tbl[13] = mk(0,  1,  2, 0,  0, 1, 1, O_FREEZE, 3, 2, 4); // freeze beats branch
        tbl[14] = mk(0,  1,  2, 0,  0, 0, 0, O_NORM,   3, 2, 4);
        tbl[15] = mk(0,  1,  6, 1,  6, 0, 0, O_BUBBLE, 4, 2, 4);
        tbl[16] = mk(0,  6,  3, 1,  6, 0, 0, O_BUBBLE, 5, 2, 4);
        tbl[17] = mk(0, 31, 31, 1, 31, 0, 0, O_BUBBLE, 6, 2, 4);

        rst_i = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, O_IDLE, 0, 0, 0));
        #3;
        chk_outs("reset", -1, O_IDLE);
        chk_cnts("reset", -1, 0, 0, 0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i]);
            #3;
            chk_outs("vec", i, tbl[i].outs);
            @(posedge clk_i); #1;
            chk_cnts("vec", i, tbl[i].stall, tbl[i].flush, tbl[i].freeze);
            $display("vec %0d: outs=%b stall=%0d flush=%0d freeze=%0d sat_stall=%0d",
                     i, {NoOp_o, PCWrite_o, IFID_Write_o, IFID_Flush_o, Freeze_o},
                     stall_cnt_o, flush_cnt_o, freeze_cnt_o, s_stall_cnt_o);
        end

        // Enter FREEZE, then reset asynchronously in the middle of it.
        drive(mk(0, 1, 2, 0, 0, 0, 1, O_FREEZE, 0, 0, 0));
        #3;
        chk_outs("frz_enter", 0, O_FREEZE);
        @(posedge clk_i); #2;
        chk_outs("frz_hold", 0, O_FREEZE);
        chk("frz_cnt", 0, freeze_cnt_o, 5);
        rst_i = 1'b0;
        #1;
        chk_outs("async_rst", 0, O_IDLE);
        chk_cnts("async_rst", 0, 0, 0, 0);
        $display("async reset mid-freeze: outs=%b stall=%0d freeze=%0d",
                 {NoOp_o, PCWrite_o, IFID_Write_o, IFID_Flush_o, Freeze_o},
                 stall_cnt_o, freeze_cnt_o);
        @(posedge clk_i); #1;
        drive(mk(0, 1, 2, 0, 0, 0, 0, O_IDLE, 0, 0, 0));
        rst_i = 1'b1;

        // Reset release alone must not leave IDLE.
        @(posedge clk_i); #1;
        chk_outs("rel_idle", 0, O_IDLE);
        @(posedge clk_i); #1;
        chk_outs("rel_idle", 1, O_IDLE);

        // start pulse: IDLE outputs until the edge, then RUN.
        start_i = 1'b1;
        #3;
        chk_outs("start", 0, O_IDLE);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        #3;
        chk_outs("start", 1, O_NORM);
        $display("restart: outs=%b", {NoOp_o, PCWrite_o, IFID_Write_o, IFID_Flush_o, Freeze_o});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
